// File: rtl/connect4_board_judge_if.sv
// Drop-request handshake between the column calculator and the board judge.
interface connect4_board_judge_if;
   logic       drop_valid;
   logic [3:0] drop_pos;
   logic       drop_player;
   logic       drop_ready;

   modport master (output drop_valid, output drop_pos, output drop_player, input drop_ready);
   modport slave  (input drop_valid, input drop_pos, input drop_player, output drop_ready);
endinterface

// File: rtl/connect4_board_judge.sv
// 4x4 connect-four judge: validates a drop, records it, scans the 10 win lines
// one per cycle and reports win/draw/continue.
module connect4_board_judge #(
   parameter bit          TURN_ENFORCE = 1'b1,
   parameter int unsigned SCAN_LINES   = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  new_game,
   connect4_board_judge_if.slave drop,
   output logic [15:0]           board_p1,
   output logic [15:0]           board_p2,
   output logic                  current_player,
   output logic                  busy,
   output logic                  result_valid,
   output logic [1:0]            winner,
   output logic                  move_error
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REPORT, S_OVER} state_t;

   localparam logic [3:0] LAST_LINE = 4'(SCAN_LINES - 1);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_board_p1, w_board_p1_nxt;
   logic [15:0] r_board_p2, w_board_p2_nxt;
   logic        r_cur, w_cur_nxt;
   logic        r_mover, w_mover_nxt;
   logic [3:0]  r_line_idx, w_line_idx_nxt;
   logic        r_win, w_win_nxt;
   logic [1:0]  r_winner, w_winner_nxt;
   logic        r_move_error, w_move_error_nxt;

   logic [15:0] w_occ;
   logic [15:0] w_cell;
   logic [15:0] w_mask;
   logic [15:0] w_mover_bd;
   logic        w_win_now;
   logic        w_legal;

   // Rows 0-3, columns 4-7, then the two diagonals.
   function automatic logic [15:0] line_mask(input logic [3:0] idx);
      case (idx)
         4'd0:    line_mask = 16'h000F;
         4'd1:    line_mask = 16'h00F0;
         4'd2:    line_mask = 16'h0F00;
         4'd3:    line_mask = 16'hF000;
         4'd4:    line_mask = 16'h1111;
         4'd5:    line_mask = 16'h2222;
         4'd6:    line_mask = 16'h4444;
         4'd7:    line_mask = 16'h8888;
         4'd8:    line_mask = 16'h8421;
         4'd9:    line_mask = 16'h1248;
         default: line_mask = '0;
      endcase
   endfunction

   assign w_occ      = r_board_p1 | r_board_p2;
   assign w_cell     = 16'(1) << drop.drop_pos;
   assign w_mask     = line_mask(r_line_idx);
   assign w_mover_bd = r_mover ? r_board_p2 : r_board_p1;
   assign w_win_now  = r_win | ((w_mover_bd & w_mask) == w_mask);

   // Gravity: bottom row, or the cell directly below is already taken.
   assign w_legal = ((w_occ & w_cell) == '0)
                 && ((drop.drop_pos < 4'd4) || ((w_occ & (w_cell >> 4)) != '0))
                 && (!TURN_ENFORCE || (drop.drop_player == r_cur));

   always_comb begin
      w_state_nxt      = r_state;
      w_board_p1_nxt   = r_board_p1;
      w_board_p2_nxt   = r_board_p2;
      w_cur_nxt        = r_cur;
      w_mover_nxt      = r_mover;
      w_line_idx_nxt   = r_line_idx;
      w_win_nxt        = r_win;
      w_winner_nxt     = r_winner;
      w_move_error_nxt = 1'b0;
      drop.drop_ready  = 1'b0;
      busy             = 1'b0;
      result_valid     = 1'b0;

      case (r_state)
         S_IDLE: begin
            drop.drop_ready = 1'b1;
            if (drop.drop_valid) begin
               if (w_legal) begin
                  if (drop.drop_player) w_board_p2_nxt = r_board_p2 | w_cell;
                  else                  w_board_p1_nxt = r_board_p1 | w_cell;
                  w_mover_nxt    = drop.drop_player;
                  w_cur_nxt      = ~r_cur;
                  w_line_idx_nxt = '0;
                  w_win_nxt      = 1'b0;
                  w_state_nxt    = S_CHECK;
               end else begin
                  w_move_error_nxt = 1'b1;
               end
            end
         end
         S_CHECK: begin
            busy      = 1'b1;
            w_win_nxt = w_win_now;
            if (r_line_idx == LAST_LINE) begin
               // Result is resolved on the last scan edge so REPORT shows it directly.
               w_line_idx_nxt = '0;
               w_state_nxt    = S_REPORT;
               if (w_win_now)    w_winner_nxt = r_mover ? 2'b10 : 2'b01;
               else if (&w_occ)  w_winner_nxt = 2'b11;
               else              w_winner_nxt = 2'b00;
            end else begin
               w_line_idx_nxt = r_line_idx + 4'd1;
            end
         end
         S_REPORT: begin
            busy         = 1'b1;
            result_valid = 1'b1;
            w_state_nxt  = (r_winner != 2'b00) ? S_OVER : S_IDLE;
         end
         S_OVER: begin
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (new_game) begin
         w_state_nxt      = S_IDLE;
         w_board_p1_nxt   = '0;
         w_board_p2_nxt   = '0;
         w_cur_nxt        = 1'b0;
         w_line_idx_nxt   = '0;
         w_win_nxt        = 1'b0;
         w_winner_nxt     = 2'b00;
         w_move_error_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_board_p1   <= '0;
         r_board_p2   <= '0;
         r_cur        <= 1'b0;
         r_mover      <= 1'b0;
         r_line_idx   <= '0;
         r_win        <= 1'b0;
         r_winner     <= 2'b00;
         r_move_error <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_board_p1   <= w_board_p1_nxt;
         r_board_p2   <= w_board_p2_nxt;
         r_cur        <= w_cur_nxt;
         r_mover      <= w_mover_nxt;
         r_line_idx   <= w_line_idx_nxt;
         r_win        <= w_win_nxt;
         r_winner     <= w_winner_nxt;
         r_move_error <= w_move_error_nxt;
      end
   end

   assign board_p1       = r_board_p1;
   assign board_p2       = r_board_p2;
   assign current_player = r_cur;
   assign winner         = r_winner;
   assign move_error     = r_move_error;

endmodule

// File: tb/tb_connect4_board_judge.sv
// Bench for connect4_board_judge: two instances (turn enforcement on/off) driven
// by the same directed moves and checked every cycle against a game-rule model.
module tb_connect4_board_judge;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       new_game = 1'b0;
   logic       tb_valid = 1'b0;
   logic [3:0] tb_pos = '0;
   logic       tb_player = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   connect4_board_judge_if if0();
   connect4_board_judge_if if1();
   assign if0.drop_valid  = tb_valid;
   assign if0.drop_pos    = tb_pos;
   assign if0.drop_player = tb_player;
   assign if1.drop_valid  = tb_valid;
   assign if1.drop_pos    = tb_pos;
   assign if1.drop_player = tb_player;

   logic [15:0] bp1_0, bp2_0, bp1_1, bp2_1;
   logic        cur_0, busy_0, rv_0, err_0, cur_1, busy_1, rv_1, err_1;
   logic [1:0]  win_0, win_1;

   connect4_board_judge #(.TURN_ENFORCE(1'b1), .SCAN_LINES(10)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .new_game(new_game), .drop(if0),
      .board_p1(bp1_0), .board_p2(bp2_0), .current_player(cur_0), .busy(busy_0),
      .result_valid(rv_0), .winner(win_0), .move_error(err_0));

   connect4_board_judge #(.TURN_ENFORCE(1'b0), .SCAN_LINES(10)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .new_game(new_game), .drop(if1),
      .board_p1(bp1_1), .board_p2(bp2_1), .current_player(cur_1), .busy(busy_1),
      .result_valid(rv_1), .winner(win_1), .move_error(err_1));

   // Game-level model: age counts cycles since the accepting edge (0 = not busy).
   logic [15:0] m_p1  [2];
   logic [15:0] m_p2  [2];
   logic        m_cur [2];
   logic [1:0]  m_win [2];
   logic [1:0]  m_pend[2];
   logic        m_err [2];
   logic        m_over[2];
   int          m_age [2];

   function automatic bit has_line(input logic [15:0] bd);
      bit ok;
      for (int r = 0; r < 4; r++) begin
         ok = 1'b1;
         for (int c = 0; c < 4; c++) ok &= bd[r*4+c];
         if (ok) return 1'b1;
      end
      for (int c = 0; c < 4; c++) begin
         ok = 1'b1;
         for (int r = 0; r < 4; r++) ok &= bd[r*4+c];
         if (ok) return 1'b1;
      end
      ok = 1'b1;
      for (int i = 0; i < 4; i++) ok &= bd[5*i];
      if (ok) return 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) ok &= bd[3+3*i];
      return ok;
   endfunction

   task automatic model_clear(input int k);
      m_p1[k] = '0; m_p2[k] = '0; m_cur[k] = 1'b0; m_win[k] = 2'b00;
      m_pend[k] = 2'b00; m_err[k] = 1'b0; m_over[k] = 1'b0; m_age[k] = 0;
   endtask

   initial begin
      int  p;
      bit  legal;
      logic [15:0] occ;
      model_clear(0);
      model_clear(1);
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               model_clear(k);
            end else begin
               m_err[k] = 1'b0;
               if (new_game) begin
                  model_clear(k);
               end else if (m_age[k] > 0) begin
                  m_age[k]++;
                  if (m_age[k] == 11) m_win[k] = m_pend[k];
                  else if (m_age[k] == 12) begin
                     m_age[k]  = 0;
                     m_over[k] = (m_win[k] != 2'b00);
                  end
               end else if (!m_over[k] && tb_valid) begin
                  p     = int'(tb_pos);
                  occ   = m_p1[k] | m_p2[k];
                  legal = !occ[p] && (p < 4 || occ[(p >= 4) ? p-4 : 0])
                       && (k == 1 || tb_player == m_cur[k]);
                  if (legal) begin
                     if (tb_player) m_p2[k][p] = 1'b1;
                     else           m_p1[k][p] = 1'b1;
                     m_cur[k] = ~m_cur[k];
                     m_age[k] = 1;
                     if (has_line(tb_player ? m_p2[k] : m_p1[k])) m_pend[k] = tb_player ? 2'b10 : 2'b01;
                     else if ((m_p1[k] | m_p2[k]) == 16'hFFFF)     m_pend[k] = 2'b11;
                     else                                          m_pend[k] = 2'b00;
                  end else begin
                     m_err[k] = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_dut(input int k, input logic [15:0] p1, input logic [15:0] p2,
                          input logic cur, input logic bsy, input logic rv,
                          input logic [1:0] w, input logic er, input logic rdy);
      chk($sformatf("dut%0d.board_p1", k), 32'(p1), 32'(m_p1[k]));
      chk($sformatf("dut%0d.board_p2", k), 32'(p2), 32'(m_p2[k]));
      chk($sformatf("dut%0d.current_player", k), 32'(cur), 32'(m_cur[k]));
      chk($sformatf("dut%0d.busy", k), 32'(bsy), 32'(m_age[k] > 0));
      chk($sformatf("dut%0d.result_valid", k), 32'(rv), 32'(m_age[k] == 11));
      chk($sformatf("dut%0d.winner", k), 32'(w), 32'(m_win[k]));
      chk($sformatf("dut%0d.move_error", k), 32'(er), 32'(m_err[k]));
      chk($sformatf("dut%0d.drop_ready", k), 32'(rdy), 32'(m_age[k] == 0 && !m_over[k]));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cmp_dut(0, bp1_0, bp2_0, cur_0, busy_0, rv_0, win_0, err_0, if0.drop_ready);
         cmp_dut(1, bp1_1, bp2_1, cur_1, busy_1, rv_1, win_1, err_1, if1.drop_ready);
      end
   end

   task automatic drop(input logic pl, input logic [3:0] p);
      @(negedge clk);
      tb_valid = 1'b1; tb_pos = p; tb_player = pl;
      @(negedge clk);
      tb_valid = 1'b0;
   endtask

   task automatic play(input logic pl, input logic [3:0] p);
      drop(pl, p);
      repeat (12) @(negedge clk);
   endtask

   task automatic restart();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [7:0] diag_seq [10];
      logic [7:0] draw_seq [16];
      diag_seq = '{8'h00, 8'h12, 8'h01, 8'h13, 8'h04, 8'h16, 8'h05, 8'h19, 8'h08, 8'h1C};
      draw_seq = '{8'h00, 8'h12, 8'h01, 8'h13, 8'h06, 8'h14, 8'h07, 8'h15,
                   8'h08, 8'h1A, 8'h09, 8'h1B, 8'h0E, 8'h1C, 8'h0F, 8'h1D};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset drop_ready", 32'(if0.drop_ready), 32'd1);
      chk("reset winner", 32'(win_0), 32'd0);

      // 1: first move, latency to result_valid
      drop(1'b0, 4'd0);
      chk("t1 drop_ready low", 32'(if0.drop_ready), 32'd0);
      n = 1;
      while (!rv_0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t1 result latency", 32'(n), 32'd11);
      chk("t1 winner", 32'(win_0), 32'd0);
      @(negedge clk);
      chk("t1 board_p1", 32'(bp1_0), 32'h0001);
      chk("t1 current_player", 32'(cur_0), 32'd1);
      chk("t1 drop_ready back", 32'(if0.drop_ready), 32'd1);

      // 2: legal stack, then a floating drop
      play(1'b1, 4'd4);
      drop(1'b0, 4'd9);
      chk("t2 move_error", 32'(err_0), 32'd1);
      chk("t2 board_p1 kept", 32'(bp1_0), 32'h0001);
      chk("t2 drop_ready", 32'(if0.drop_ready), 32'd1);

      // 3: wrong player, enforced vs not
      drop(1'b1, 4'd1);
      chk("t3 enforce error", 32'(err_0), 32'd1);
      chk("t3 no-enforce busy", 32'(busy_1), 32'd1);
      repeat (12) @(negedge clk);
      chk("t3 no-enforce board_p2", 32'(bp2_1), 32'h0012);
      restart();

      // 4: row win for P1, then OVER behaviour and new_game with a discarded drop
      play(1'b0, 4'd0); play(1'b1, 4'd4); play(1'b0, 4'd1); play(1'b1, 4'd5);
      play(1'b0, 4'd2); play(1'b1, 4'd6); play(1'b0, 4'd3);
      chk("t4 winner P1", 32'(win_0), 32'd1);
      @(negedge clk);
      tb_valid = 1'b1; tb_pos = 4'd8; tb_player = 1'b1;
      chk("t4 over drop_ready", 32'(if0.drop_ready), 32'd0);
      @(negedge clk);
      chk("t4 over no error", 32'(err_0), 32'd0);
      tb_pos = 4'd0; tb_player = 1'b0;
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0; tb_valid = 1'b0;
      chk("t4 new_game board_p1", 32'(bp1_0), 32'h0000);
      chk("t4 new_game board_p2", 32'(bp2_0), 32'h0000);
      chk("t4 new_game ready", 32'(if0.drop_ready), 32'd1);

      // 5: anti-diagonal completed by P2
      foreach (diag_seq[i]) play(diag_seq[i][4], diag_seq[i][3:0]);
      chk("t5 winner P2", 32'(win_0), 32'd2);
      restart();

      // 6: full board, no line
      foreach (draw_seq[i]) play(draw_seq[i][4], draw_seq[i][3:0]);
      chk("t6 winner draw", 32'(win_0), 32'd3);
      chk("t6 full board", 32'(bp1_0 | bp2_0), 32'h0000FFFF);
      restart();

      // async reset in the middle of a scan
      drop(1'b0, 4'd0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst board_p1", 32'(bp1_0), 32'h0000);
      chk("rst busy", 32'(busy_0), 32'd0);
      chk("rst current_player", 32'(cur_0), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst release ready", 32'(if0.drop_ready), 32'd1);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/connect4_board_judge.md
Name: connect4_board_judge

Overview:
Consumer of the drop-position stream produced by the column calculator. Accepts a cell index (row*4+col, 4x4 board, row 0 = bottom) plus the player, and validates the move. It records the move in a board register, scans all 10 winning lines sequentially, and reports win/draw/continue. It sits between the move-position logic and the display/game-control FSM.

Parameters:
TURN_ENFORCE, 1, 1 = reject drops whose player does not match the expected turn; 0 = accept either player.
SCAN_LINES, 10, number of win lines scanned per move; fixed at 10 for 4x4; other values are unsupported.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
new_game  in  1  synchronous clear of board and turn; has priority over everything except rst_n
drop_valid  in  1  drop request qualifier
drop_pos  in  4  cell index 0..15 (row*4+col)
drop_player  in  1  0 = P1, 1 = P2
drop_ready  out  1  high only in IDLE; a transfer occurs when drop_valid && drop_ready at a rising edge
board_p1  out  16  occupancy bitmap for P1, bit i = cell i
board_p2  out  16  occupancy bitmap for P2
current_player  out  1  player expected to move next
busy  out  1  high in CHECK and REPORT
result_valid  out  1  one-cycle pulse at end of each accepted move
winner  out  2  00 none, 01 P1, 10 P2, 11 draw; held until the next accepted move or new_game
move_error  out  1  one-cycle pulse for a rejected drop

Behaviour:
- Reset (rst_n=0, async) clears board_p1, board_p2, current_player, result_valid, move_error, busy and winner, and sets state=IDLE. drop_ready=1 after reset.
- States: IDLE, CHECK, REPORT, OVER.
- IDLE, legality check on a transfer:
  - Cell is free: bit drop_pos is 0 in both board_p1 and board_p2.
  - Gravity holds: drop_pos<4, or cell drop_pos-4 is occupied.
  - Turn matches: drop_player==current_player, or TURN_ENFORCE=0.
- Legal drop: set the board bit in the same edge, latch the player, toggle current_player, set line_idx=0, go to CHECK.
- Illegal drop: board and turn unchanged, move_error=1 for exactly the next cycle, remain in IDLE with drop_ready=1.
- CHECK: one line per cycle, line_idx 0..9, with exactly 10 cycles and no early exit.
  - Lines 0-3 are rows r: cells 4r..4r+3.
  - Lines 4-7 are columns c: cells c, c+4, c+8, c+12.
  - Line 8 is cells 0, 5, 10, 15; line 9 is cells 3, 6, 9, 12.
  - A sticky win flag is set if all 4 cells of the line are in the latched player's bitmap.
  - Only the mover's bitmap is tested.
- REPORT: a single cycle with result_valid=1.
  - winner = mover code if the win flag is set.
  - Otherwise winner = 11 if all 16 cells are occupied.
  - Otherwise winner = 00.
  - Next state is OVER if winner!=00, else IDLE.
- Latency: accept at edge E, CHECK during cycles E+1..E+10, result_valid high in cycle E+11, drop_ready high again from cycle E+12.
- OVER: drop_ready=0; drop_valid is ignored (no error pulse); board and winner are held. Only new_game leaves OVER.
- new_game in any state: clears the board, current_player=0, winner=00, win flag and line_idx, and goes to IDLE on the next edge. A drop presented in the same cycle is discarded.
- drop_valid held across CHECK is not consumed, because drop_ready=0.
- line_idx is 4 bits; values 10..15 never occur.

Test Plan:
1. Reset, then P1 drops pos 0 -> drop_ready falls; result_valid exactly 11 cycles after accept; winner=00; board_p1=0x0001; current_player=1.
2. P2 drops pos 4 with cell 0 occupied -> accepted. Then P1 drops pos 9 with cell 5 empty -> move_error pulse, board unchanged, drop_ready stays 1.
3. Wrong player: current_player=0, drop_player=1 with TURN_ENFORCE=1 -> move_error; with TURN_ENFORCE=0 -> accepted.
4. Alternating drops P1 0,1,2,3 and P2 4,5,6 -> after P1's pos 3, winner=01 and state OVER. A further drop_valid gets drop_ready=0 and no error. new_game returns to IDLE with both bitmaps 0.
5. Diagonal: fill so that P2 completes 3, 6, 9, 12 last -> winner=10, detected on line 9 (final CHECK cycle).
6. Fill all 16 cells with no 4-line (rows alternating pattern P1 P1 P2 P2 / P2 P2 P1 P1 ...) -> winner=11 on the 16th move. Also assert rst_n mid-CHECK -> all outputs cleared immediately, drop_ready=1 after release.
